// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: issues two INTA low pulses and captures the vector in the second one.
// Optional ACK2 timeout abort is enabled by defining INTA_TIMEOUT_EN.
module inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       IF,
  input  logic       IV_ready,
  input  logic [7:0] DATA_IN,
  input  logic       vec_ack,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vec_valid,
  output logic       busy,
  output logic       vec_err
);

  if (PULSE_W < 1 || PULSE_W > 255 || GAP_W < 1 || GAP_W > 255 ||
      TIMEOUT <= PULSE_W || TIMEOUT > 255) begin : g_param_chk
    $error("inta_sequencer: parameter out of range");
  end

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_W - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2, S_HOLD} state_t;

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       int_m, int_s;
  logic       capture, timeout;
  logic       inta_d, vec_valid_d, vec_err_d;

  // State register; INTA and status are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_m     <= 1'b0;
      int_s     <= 1'b0;
      state     <= S_IDLE;
      cnt       <= 8'd0;
      INTA      <= 1'b1;
      vector    <= 8'h00;
      vec_valid <= 1'b0;
      vec_err   <= 1'b0;
    end else begin
      int_m     <= INT;
      int_s     <= int_m;
      state     <= state_d;
      cnt       <= cnt_d;
      INTA      <= inta_d;
      vec_valid <= vec_valid_d;
      vec_err   <= vec_err_d;
      if (capture) vector <= DATA_IN;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    timeout = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (int_s && IF) state_d = S_ACK1;
      end
      S_ACK1: begin
        cnt_d = cnt + 8'd1;
        if (cnt == PULSE_LAST) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end
      end
      S_GAP: begin
        cnt_d = cnt + 8'd1;
        if (cnt == GAP_LAST) begin
          state_d = S_ACK2;
          cnt_d   = 8'd0;
        end
      end
      S_ACK2: begin
        if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
        capture = IV_ready && (cnt >= PULSE_LAST);
`ifdef INTA_TIMEOUT_EN
        timeout = !capture && (cnt == TO_LAST);
`else
        timeout = 1'b0;
`endif
        if (capture) begin
          state_d = S_HOLD;
          cnt_d   = 8'd0;
        end else if (timeout) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_HOLD: begin
        cnt_d = 8'd0;
        if (vec_ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode (values registered on the next edge)
  always_comb begin
    inta_d      = !(state_d == S_ACK1 || state_d == S_ACK2);
    vec_valid_d = (state_d == S_HOLD);
    vec_err_d   = timeout;
  end

  assign busy = (state != S_IDLE);

endmodule
